// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with a one-word holding buffer.
//
// A word is accepted when din_valid and din_ready are both high at a rising
// clock edge. Its first bit appears on sout in the next cycle, and the rest
// follow one per clock. A second word can wait in the holding register, so a
// producer that keeps din_valid high gets a gap-free bitstream.
//
// Parameters:
//   WIDTH     - parallel word width (>= 2)
//   MSB_FIRST - 1: MSB shifted out first, 0: LSB first
//   IDLE_BIT  - sout level while no word is being shifted
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - asynchronous, active-low reset
//   din        - parallel word from the producer
//   din_valid  - din holds a word to transfer
//   din_ready  - block can accept a word this cycle (registered, not a function of din_valid)
//   sout       - registered serial bit
//   busy       - sout is carrying a data bit
//   frame_done - sout is carrying the last bit of a word
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic          IDLE_LVL = (IDLE_BIT != 0);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             sout_r;
  logic             transfer;

  // Bit that leaves first for a given word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its first-out bit removed, remaining bits moved toward the
  // output end.
  function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready  = ~hold_full;
  assign transfer   = din_valid & ~hold_full;
  assign sout       = sout_r;
  assign busy       = (state == SHIFT);
  assign frame_done = (state == SHIFT) && (cnt == LAST);

  // sout is driven straight from a register. When a word is loaded, its first
  // bit goes to sout_r, and the shifter keeps only the bits still to be sent.
  // This gives a one-clock latency from transfer to first bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
      sout_r    <= IDLE_LVL;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (transfer) begin
            sout_r <= first_bit(din);
            shreg  <= drop_first(din);
            state  <= SHIFT;
          end else begin
            sout_r <= IDLE_LVL;
          end
        end

        SHIFT: begin
          if (cnt != LAST) begin
            sout_r <= first_bit(shreg);
            shreg  <= drop_first(shreg);
            cnt    <= cnt + CW'(1);
            if (transfer) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end else begin
            // Last bit of the word is on sout. Start the next word without a
            // gap: take the held word if there is one, else a word being
            // offered right now, else go idle.
            cnt <= '0;
            if (hold_full) begin
              sout_r    <= first_bit(hold);
              shreg     <= drop_first(hold);
              hold_full <= 1'b0;
            end else if (transfer) begin
              sout_r <= first_bit(din);
              shreg  <= drop_first(din);
            end else begin
              sout_r <= IDLE_LVL;
              state  <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          hold_full <= 1'b0;
          sout_r    <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: self-checking bench for bit_serializer.
// dut_a: WIDTH=8, MSB first, idle level 0. This one is checked cycle by cycle
//        against a transaction-level model.
// dut_b: WIDTH=8, LSB first, idle level 1.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din_a, din_b;
  logic         din_valid_a, din_valid_b;
  logic         din_ready_a, sout_a, busy_a, frame_done_a;
  logic         din_ready_b, sout_b, busy_b, frame_done_b;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(0)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(din_valid_a),
    .din_ready(din_ready_a), .sout(sout_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(1)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(din_valid_b),
    .din_ready(din_ready_b), .sout(sout_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  always #5 clk = ~clk;

  // Index of the most recent rising edge.
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int tests = 0;
  int fails = 0;

  // Transaction model. Each accepted word has an accept edge, a load edge and
  // its data. The word occupies sout in the cycles load..load+W-1. A word
  // loads at max(accept edge, previous load + W).
  int           m_acc[$];
  int           m_load[$];
  logic [W-1:0] m_word[$];
  int           last_load = -1000;

  function automatic void model_clear();
    m_acc.delete();
    m_load.delete();
    m_word.delete();
    last_load = -1000;
  endfunction

  // Expected {sout, busy, frame_done, din_ready} in cycle c (after edge c).
  function automatic logic [3:0] m_vec(input int c);
    logic s, b, f, r;
    s = 1'b0; b = 1'b0; f = 1'b0; r = 1'b1;
    for (int k = 0; k < m_load.size(); k++) begin
      if (c >= m_load[k] && c < m_load[k] + W) begin
        s = m_word[k][W-1-(c-m_load[k])];
        b = 1'b1;
        f = (c == m_load[k] + W - 1);
      end
      if (m_acc[k] <= c && m_load[k] > c) r = 1'b0;
    end
    return {s, b, f, r};
  endfunction

  // Drive dut_a for the next edge, record in the model whether the word is
  // accepted, then move to the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
    logic [3:0] e;
    int         a;
    din_valid_a = v;
    din_a       = d;
    acc         = 1'b0;
    e           = m_vec(edge_n);
    if (v && e[0]) begin
      a = edge_n + 1;
      m_acc.push_back(a);
      m_load.push_back((a > last_load + W) ? a : last_load + W);
      m_word.push_back(d);
      last_load = m_load[$];
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    din_a = '0; din_b = '0; din_valid_a = 1'b0; din_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sout_a, busy_a, frame_done_a, din_ready_a} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_a: got %b want 0001", {sout_a, busy_a, frame_done_a, din_ready_a});
    end
    tests++;
    if ({sout_b, busy_b, frame_done_b, din_ready_b} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_b: got %b want 1001", {sout_b, busy_b, frame_done_b, din_ready_b});
    end
    reset = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_single();
    bit acc;
    logic [3:0] e;
    step(1'b1, 8'hB4, acc);
    for (int i = 0; i < 11; i++) begin
      e = m_vec(edge_n);
      tests++;
      if ({sout_a, busy_a, frame_done_a, din_ready_a} !== e) begin
        fails++;
        $display("FAIL single cyc%0d: got %b want %b", i, {sout_a, busy_a, frame_done_a, din_ready_a}, e);
      end
      step(1'b0, 8'h00, acc);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int idx;
    logic [3:0] e;
    logic [W-1:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    idx = 0;
    for (int i = 0; i < 22; i++) begin
      if (idx < 2) begin
        step(1'b1, words[idx], acc);
        if (acc) idx++;
      end else begin
        step(1'b0, 8'h00, acc);
      end
      e = m_vec(edge_n);
      tests++;
      if ({sout_a, busy_a, frame_done_a, din_ready_a} !== e) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", i, {sout_a, busy_a, frame_done_a, din_ready_a}, e);
      end
    end
  endtask

  task automatic test_direct_load();
    bit acc;
    bit sent;
    logic [3:0] e;
    sent = 1'b0;
    step(1'b1, 8'h5A, acc);
    for (int i = 0; i < 20; i++) begin
      e = m_vec(edge_n);
      tests++;
      if ({sout_a, busy_a, frame_done_a, din_ready_a} !== e) begin
        fails++;
        $display("FAIL direct_load cyc%0d: got %b want %b", i, {sout_a, busy_a, frame_done_a, din_ready_a}, e);
      end
      if (!sent && e[1]) begin
        // This is the frame_done cycle with the hold register empty.
        step(1'b1, 8'hFF, acc);
        sent = 1'b1;
        tests++;
        if ({sout_a, busy_a} !== 2'b11) begin
          fails++;
          $display("FAIL direct_load_first_bit: got %b want 11", {sout_a, busy_a});
        end
      end else begin
        step(1'b0, $urandom_range(255, 0), acc);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    logic [3:0] e;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99, 0) < 60), $urandom_range(255, 0), acc);
      e = m_vec(edge_n);
      tests++;
      if ({sout_a, busy_a, frame_done_a, din_ready_a} !== e) begin
        fails++;
        $display("FAIL random cyc%0d: got %b want %b", i, {sout_a, busy_a, frame_done_a, din_ready_a}, e);
      end
    end
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00, acc);
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    logic [1:0]   e;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 8'h01 : W'($urandom_range(255, 0));
      din_b = w;
      din_valid_b = 1'b1;
      @(negedge clk);
      din_valid_b = 1'b0;
      din_b = ~w;
      for (int i = 0; i < W + 3; i++) begin
        e = (i < W) ? {w[i], 1'b1} : 2'b10;
        tests++;
        if ({sout_b, busy_b} !== e) begin
          fails++;
          $display("FAIL lsb_first w=%h bit%0d: got %b want %b", w, i, {sout_b, busy_b}, e);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    bit acc;
    logic [3:0] e;
    step(1'b1, 8'hF0, acc);
    step(1'b1, 8'h0F, acc);
    step(1'b0, 8'h00, acc);
    reset = 1'b0;
    #1;
    tests++;
    if ({sout_a, busy_a, frame_done_a, din_ready_a} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_mid_word: got %b want 0001", {sout_a, busy_a, frame_done_a, din_ready_a});
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, acc);
      e = m_vec(edge_n);
      tests++;
      if ({sout_a, busy_a, frame_done_a, din_ready_a} !== e) begin
        fails++;
        $display("FAIL after_reset cyc%0d: got %b want %b", i, {sout_a, busy_a, frame_done_a, din_ready_a}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_direct_load();
    test_random();
    test_lsb_first();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = MSB shifted out first, 0 = LSB first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, giving the sout level when no word is being shifted.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 din  input  WIDTH  parallel word offered by the producer.
REQ-007 din_valid  input  1  din holds a word to transfer.
REQ-008 din_ready  output  1  block can accept a word this cycle; a transfer occurs when din_valid=1 and din_ready=1 at a rising edge.
REQ-009 sout  output  1  registered serial bitstream, one bit per clock, for the downstream per-clock bit sampler.
REQ-010 busy  output  1  high while sout carries a data bit.
REQ-011 frame_done  output  1  one-cycle pulse, high in the cycle sout carries the last bit of a word.

Function
REQ-012 The block SHALL contain a WIDTH-bit shift register, a bit counter of ceil(log2(WIDTH)) bits, a one-word holding register with full flag, and a two-state FSM: IDLE, SHIFT.
REQ-013 din_ready SHALL be the inverse of the registered hold-full flag; it SHALL NOT depend combinationally on din_valid.
REQ-014 IDLE: sout=IDLE_BIT, busy=0, counter=0; on a transfer the word SHALL load into the shifter, and on the next cycle the FSM SHALL be in SHIFT with sout = first bit (din[WIDTH-1] if MSB_FIRST else din[0]).
REQ-015 Transfer-to-first-bit latency SHALL be exactly 1 clock.
REQ-016 SHIFT: each clock SHALL advance sout to the next bit in MSB_FIRST order and increment the counter; exactly WIDTH bits SHALL appear per word.
REQ-017 In SHIFT, a transfer while the counter is not WIDTH-1 SHALL write din into the holding register and set hold-full.
REQ-018 At counter = WIDTH-1 with hold-full=1, the holding word SHALL load into the shifter, hold-full SHALL clear, and the FSM SHALL stay in SHIFT with counter=0 (no idle gap).
REQ-019 At counter = WIDTH-1 with hold-full=0 and a transfer in the same cycle, din SHALL load directly into the shifter, bypass the holding register, and the FSM SHALL stay in SHIFT with no gap.
REQ-020 At counter = WIDTH-1 with hold-full=0 and no transfer, the FSM SHALL go to IDLE; sout SHALL be IDLE_BIT the next cycle.
REQ-021 frame_done SHALL be 1 exactly when the FSM is in SHIFT and counter = WIDTH-1.
REQ-022 busy SHALL be 1 exactly when the FSM is in SHIFT.
REQ-023 din SHALL be sampled only on a transfer edge; changes to din at other times SHALL have no effect.
REQ-024 Sustained valid input SHALL yield a gap-free stream, throughput one word per WIDTH clocks; din_ready SHALL deassert while a second word waits in the holding register.
REQ-025 The FSM SHALL have no reachable state other than IDLE and SHIFT; any undefined encoding SHALL return to IDLE.

Reset
REQ-026 While reset=0: FSM=IDLE, shifter=0, counter=0, hold-full=0, holding register=0, sout=IDLE_BIT, busy=0, frame_done=0, din_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the partial word and any held word; no further bits of either SHALL appear after release.
REQ-028 After reset release, the first transfer SHALL be accepted at the first rising edge with din_valid=1.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1: single transfer of 8'hB4 -> sout 1,0,1,1,0,1,0,0 on the 8 clocks after the transfer, frame_done high on the 8th, then sout=0, busy=0.
REQ-030 Back-to-back 8'hA5 then 8'h3C, din_valid held -> 16 contiguous bits 10100101 00111100, busy high all 16 clocks, two frame_done pulses 8 clocks apart, din_ready low while 8'h3C is held.
REQ-031 Transfer of 8'hFF exactly on the frame_done cycle of a prior word with hold empty -> direct load, next bit is 1 with no IDLE_BIT gap.
REQ-032 MSB_FIRST=0, IDLE_BIT=1: transfer of 8'h01 -> sout 1,0,0,0,0,0,0,0, then constant 1.
REQ-033 reset pulsed low after 3 bits of 8'hF0 with 8'h0F held -> immediate sout=IDLE_BIT, busy=0, din_ready=1; neither remaining word appears after release.
